// File: rtl/ad7763_pkg.sv
// Shared widths, register offsets and FSM encodings for the AD7763 bridge.
package ad7763_pkg;

  localparam int ADC_DATA_BITS = 24;
  localparam int CFG_WORD_BITS = 32;

  localparam logic [3:0] REG_CFG    = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  // SER_WAIT parks a latched word until the next SCO fall so FSI# is a full SCO period
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_WAIT,
    SER_FSYNC,
    SER_SHIFT
  } ser_state_t;

endpackage

// File: rtl/ad7763_sync_edge.sv
// Two-flop synchronizer for one asynchronous ADC pin, with rise/fall strobes of the synced value.
// Latency: q follows din after 2 clk; rise/fall are single-cycle strobes aligned with the change of q.
// Backpressure: none, free-running.
module ad7763_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/axi_axis_ad7763.sv
// AD7763 bridge: serial conversion frames -> AXI4-Stream samples; AXI4-Lite config words -> FSI#/SDI.
// Latency: sample on tdata 1 aclk after its 24th SCO bit; config word starts on the first SCO fall after acceptance.
// Backpressure: full output drops new samples (counted if AD7763_OVF_COUNT_EN); wready held low while a word is serializing.
module axi_axis_ad7763 import ad7763_pkg::*; #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXIS_WIDTH     = 24
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic                      adc_sco,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXIS_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_aclk,
  input  logic                      adc_dreadyn,
  input  logic                      adc_sdo,
  output logic                      adc_fsin,
  output logic                      adc_sdi
);

  logic sco_s, sco_rise, sco_fall;
  logic drdy_s, drdy_rise_unused, drdy_fall_unused;
  logic sdo_s, sdo_rise_unused, sdo_fall_unused;

  ad7763_sync_edge #(.RST_VAL(1'b0)) u_sync_sco (
    .clk(aclk), .rst(rst), .din(adc_sco), .q(sco_s), .rise(sco_rise), .fall(sco_fall)
  );
  // DRDY# resets to its idle level so a reset release never looks like a frame start
  ad7763_sync_edge #(.RST_VAL(1'b1)) u_sync_drdy (
    .clk(aclk), .rst(rst), .din(adc_dreadyn), .q(drdy_s), .rise(drdy_rise_unused), .fall(drdy_fall_unused)
  );
  ad7763_sync_edge #(.RST_VAL(1'b0)) u_sync_sdo (
    .clk(aclk), .rst(rst), .din(adc_sdo), .q(sdo_s), .rise(sdo_rise_unused), .fall(sdo_fall_unused)
  );

  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axi_awaddr, s_axi_awvalid, sco_s,
                           s_axi_araddr[AXI_DATA_WIDTH-1:3], s_axi_araddr[1:0]};

  rx_state_t                rx_state;
  logic [4:0]               rx_cnt;
  logic [ADC_DATA_BITS-1:0] rx_shreg;
  logic                     rx_done;
  logic [15:0]              ovf_count;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shreg <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (sco_rise) begin
        case (rx_state)
          RX_IDLE: begin
            if (!drdy_s) begin
              rx_state <= RX_SHIFT;
              rx_cnt   <= '0;
            end
          end
          default: begin
            if (!drdy_s) begin
              rx_cnt <= '0;
            end else begin
              rx_shreg <= {rx_shreg[ADC_DATA_BITS-2:0], sdo_s};
              if (rx_cnt == 5'(ADC_DATA_BITS - 1)) begin
                rx_state <= RX_IDLE;
                rx_done  <= 1'b1;
              end else begin
                rx_cnt <= rx_cnt + 5'd1;
              end
            end
          end
        endcase
      end
    end
  end

`ifndef AD7763_OVF_COUNT_EN
  assign ovf_count = 16'h0;
`endif

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
`ifdef AD7763_OVF_COUNT_EN
      ovf_count     <= '0;
`endif
    end else if (rx_done) begin
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tdata  <= rx_shreg;
        m_axis_tvalid <= 1'b1;
      end else begin
`ifdef AD7763_OVF_COUNT_EN
        if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
`endif
      end
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  ser_state_t               ser_state;
  logic [CFG_WORD_BITS-1:0] cfg_word;
  logic [CFG_WORD_BITS-1:0] ser_sr;
  logic [5:0]               ser_cnt;
  logic                     busy;

  assign busy          = (ser_state != SER_IDLE);
  assign s_axi_wready  = ~busy & ~s_axi_bvalid;
  assign s_axi_awready = s_axi_wready;
  assign s_axi_bresp   = 2'b00;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      ser_state    <= SER_IDLE;
      cfg_word     <= '0;
      ser_sr       <= '0;
      ser_cnt      <= '0;
      s_axi_bvalid <= 1'b0;
      adc_fsin     <= 1'b1;
      adc_sdi      <= 1'b0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        cfg_word     <= s_axi_wdata;
        ser_sr       <= s_axi_wdata;
        ser_state    <= SER_WAIT;
        s_axi_bvalid <= 1'b1;
      end else if (sco_fall) begin
        case (ser_state)
          SER_WAIT: begin
            adc_fsin  <= 1'b0;
            ser_state <= SER_FSYNC;
          end
          SER_FSYNC: begin
            adc_fsin  <= 1'b1;
            adc_sdi   <= ser_sr[CFG_WORD_BITS-1];
            ser_sr    <= {ser_sr[CFG_WORD_BITS-2:0], 1'b0};
            ser_cnt   <= 6'd1;
            ser_state <= SER_SHIFT;
          end
          SER_SHIFT: begin
            if (ser_cnt == 6'(CFG_WORD_BITS)) begin
              adc_sdi   <= 1'b0;
              ser_state <= SER_IDLE;
            end else begin
              adc_sdi <= ser_sr[CFG_WORD_BITS-1];
              ser_sr  <= {ser_sr[CFG_WORD_BITS-2:0], 1'b0};
              ser_cnt <= ser_cnt + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [AXI_DATA_WIDTH-1:0] status_word;
  assign status_word   = {busy, 15'b0, ovf_count};
  assign s_axi_arready = ~s_axi_rvalid;
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      case (s_axi_araddr[2])
        REG_CFG[2]:    s_axi_rdata <= cfg_word;
        REG_STATUS[2]: s_axi_rdata <= status_word;
      endcase
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  assign m_axis_aclk = aclk;

endmodule

// File: tb/tb_axi_axis_ad7763.sv
// Directed bench for axi_axis_ad7763: ADC frames, overflow hold, config writes, reset abort.
module tb_axi_axis_ad7763;

  logic        aclk = 1'b0;
  logic        rst = 1'b0;
  logic        adc_sco = 1'b0;
  logic        adc_dreadyn = 1'b1;
  logic        adc_sdo = 1'b0;
  logic [11:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_aclk;
  logic        adc_fsin;
  logic        adc_sdi;

`ifdef AD7763_OVF_COUNT_EN
  localparam logic [15:0] OVF_EXP = 16'd19;
`else
  localparam logic [15:0] OVF_EXP = 16'd0;
`endif

  axi_axis_ad7763 dut (
    .aclk(aclk), .rst(rst), .adc_sco(adc_sco),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_aclk(m_axis_aclk),
    .adc_dreadyn(adc_dreadyn), .adc_sdo(adc_sdo), .adc_fsin(adc_fsin), .adc_sdi(adc_sdi)
  );

  always #5 aclk = ~aclk;

  // SCO period 25 with edges offset so they never land on an aclk edge
  initial begin
    #2;
    forever begin
      adc_sco = 1'b1;
      #12;
      adc_sco = 1'b0;
      #13;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [23:0] axis_q[$];
  logic [31:0] wq[$];
  int          hold_viol = 0;
  logic        hold_prev = 1'b0;
  logic [23:0] hold_dat = '0;
  int          bv_cnt = 0;
  int          fs_cnt = 0;
  int          ser_left = 0;
  logic [31:0] ser_word = '0;

  // Inputs change only at posedge+2, so negedge sees what the next posedge will see
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) axis_q.push_back(m_axis_tdata);
    if (hold_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_dat)) hold_viol++;
    hold_prev = m_axis_tvalid && !m_axis_tready;
    hold_dat  = m_axis_tdata;
    if (s_axi_bvalid) bv_cnt++;
  end

  // One sample per SCO period, taken mid-way through each serializer output state
  always @(posedge adc_sco) begin
    if (!adc_fsin) begin
      fs_cnt++;
      ser_left = 32;
      ser_word = '0;
    end else if (ser_left > 0) begin
      ser_word = {ser_word[30:0], adc_sdi};
      ser_left--;
      if (ser_left == 0) wq.push_back(ser_word);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] axis_at(input int i);
    return (i < axis_q.size()) ? 32'(axis_q[i]) : 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic adc_frame(input logic [23:0] d);
    @(negedge adc_sco);
    adc_dreadyn = 1'b0;
    adc_sdo = 1'b0;
    @(negedge adc_sco);
    adc_dreadyn = 1'b1;
    adc_sdo = d[23];
    for (int i = 22; i >= 0; i--) begin
      @(negedge adc_sco);
      adc_sdo = d[i];
    end
    repeat (8) begin
      @(negedge adc_sco);
      adc_sdo = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [31:0] d);
    int t = 0;
    s_axi_wdata = d;
    s_axi_wvalid = 1'b1;
    s_axi_awvalid = 1'b1;
    while (!s_axi_wready && t < 400) begin
      tick(1);
      t++;
    end
    check("wr_accept_in_time", 32'(t < 400), 32'd1);
    tick(1);
    s_axi_wvalid = 1'b0;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int t = 0;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && t < 50) begin
      tick(1);
      t++;
    end
    tick(1);
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && t < 50) begin
      tick(1);
      t++;
    end
    check("rd_in_time", 32'(t < 50), 32'd1);
    d = s_axi_rdata;
    tick(1);
  endtask

  initial begin
    logic [31:0] rd;
    int t;

    #1 rst = 1'b1;
    #2;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd1);
    check("rst_awready", 32'(s_axi_awready), 32'd1);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_fsin", 32'(adc_fsin), 32'd1);
    check("rst_sdi", 32'(adc_sdi), 32'd0);
    #8 rst = 1'b0;
    tick(1);

    m_axis_tready = 1'b1;
    adc_frame(24'h000001);
    adc_frame(24'h000002);
    tick(5);
    check("rx_count", 32'(axis_q.size()), 32'd2);
    check("rx_sample0", axis_at(0), 32'h000001);
    check("rx_sample1", axis_at(1), 32'h000002);
    check("rx_tvalid_idle", 32'(m_axis_tvalid), 32'd0);

    m_axis_tready = 1'b0;
    adc_frame(24'h000001);
    for (int i = 1; i <= 19; i++) adc_frame(24'(256 + i));
    tick(2);
    check("ovf_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("ovf_hold_tdata", 32'(m_axis_tdata), 32'h000001);
    axi_read(32'h4, rd);
    check("ovf_status", rd, {1'b0, 15'b0, OVF_EXP});
    m_axis_tready = 1'b1;
    tick(3);
    check("ovf_release_count", 32'(axis_q.size()), 32'd3);
    check("ovf_release_data", axis_at(2), 32'h000001);
    check("ovf_release_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("hold_stable", 32'(hold_viol), 32'd0);

    axi_write(32'h11FF3355);
    tick(3);
    check("bvalid_pulse1", 32'(bv_cnt), 32'd1);
    axi_read(32'h4, rd);
    check("status_busy", rd, {1'b1, 15'b0, OVF_EXP});
    axi_read(32'h0, rd);
    check("cfg_readback1", rd, 32'h11FF3355);
    check("wready_busy", 32'(s_axi_wready), 32'd0);
    axi_write(32'hFFFFFFFF);
    check("second_after_first", 32'(wq.size()), 32'd1);
    t = 0;
    while (wq.size() < 2 && t < 400) begin
      tick(1);
      t++;
    end
    tick(10);
    check("ser_word_count", 32'(wq.size()), 32'd2);
    check("ser_word0", wq_at(0), 32'h11FF3355);
    check("ser_word1", wq_at(1), 32'hFFFFFFFF);
    check("fsin_low_periods", 32'(fs_cnt), 32'd2);
    check("fsin_idle", 32'(adc_fsin), 32'd1);
    check("sdi_idle", 32'(adc_sdi), 32'd0);
    check("bvalid_pulse2", 32'(bv_cnt), 32'd2);
    axi_read(32'h0, rd);
    check("cfg_readback2", rd, 32'hFFFFFFFF);
    axi_read(32'h4, rd);
    check("status_idle", rd, {1'b0, 15'b0, OVF_EXP});

    // Start a write and a frame, then reset in the middle of both
    axi_write(32'hA5A5A5A5);
    @(negedge adc_sco);
    adc_dreadyn = 1'b0;
    @(negedge adc_sco);
    adc_dreadyn = 1'b1;
    adc_sdo = 1'b1;
    repeat (6) begin
      @(negedge adc_sco);
      adc_sdo = ~adc_sdo;
    end
    check("mid_write_fsin_seen", 32'(fs_cnt), 32'd3);
    #3 rst = 1'b1;
    #2;
    check("abort_fsin", 32'(adc_fsin), 32'd1);
    check("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("abort_wready", 32'(s_axi_wready), 32'd1);
    adc_sdo = 1'b0;
    #20 rst = 1'b0;
    adc_frame(24'h0000AB);
    tick(3);
    check("post_rst_count", 32'(axis_q.size()), 32'd4);
    check("post_rst_sample", axis_at(3), 32'h0000AB);
    axi_read(32'h4, rd);
    check("post_rst_status", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_axis_ad7763.md
Name: axi_axis_ad7763

Overview:
- AD7763 (24-bit sigma-delta ADC) serial-interface bridge.
- Receive path: deserializes conversion frames (DRDY#, SCO, SDO) and presents each 24-bit sample on an AXI4-Stream master.
- Config path: an AXI4-Lite slave accepts 32-bit config words and serializes them to the ADC register port (FSI#, SDI).
- Everything runs on one system clock; ADC interface signals are treated as asynchronous inputs.

Parameters:
- AXI_ADDR_WIDTH, 12: width of s_axi_awaddr.
- AXI_DATA_WIDTH, 32: width of s_axi_wdata, s_axi_rdata and s_axi_araddr.
- AXIS_WIDTH, 24: width of m_axis_tdata; must equal 24.

Ports:
- aclk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- adc_sco  in  1  ADC serial clock out, 40 MHz; sampled as data, never used as a clock.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address, ignored.
- s_axi_awvalid  in  1  ignored.
- s_axi_awready  out  1  equals s_axi_wready.
- s_axi_wdata  in  32  config word.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  always 2'b00.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  AXI_DATA_WIDTH  only bit 2 decoded.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- m_axis_tdata  out  24  ADC sample, two's complement.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  sample accepted.
- m_axis_aclk  out  1  direct copy of aclk.
- adc_dreadyn  in  1  ADC DRDY#, active-low frame marker.
- adc_sdo  in  1  ADC serial data out.
- adc_fsin  out  1  ADC FSI#, active-low write frame sync.
- adc_sdi  out  1  ADC serial data in.

Behaviour:
- Synchronization: adc_sco, adc_dreadyn and adc_sdo each pass through 2-FF synchronizers.
  - sco_rise = synced SCO high and previous synced SCO low; sco_fall is the inverse.
- Receive FSM:
  - IDLE: on sco_rise with synced DRDY# = 0, go to SHIFT with bit count 0.
  - SHIFT: on each sco_rise, shift synced SDO into a 24-bit register, MSB first.
  - After the 24th bit, go to IDLE. Status bits and tri-state bits are ignored.
  - DRDY# low seen while in SHIFT restarts the frame at bit 0; the partial sample is discarded.
- Output register:
  - One aclk after the 24th bit, the sample loads into m_axis_tdata and m_axis_tvalid rises, provided the output is empty or is accepted in that same cycle.
  - The output is held stable until tvalid and tready are both high.
  - A new sample arriving while the output is full and not being accepted is dropped (the held sample is kept) and the overflow counter increments, saturating at 0xFFFF.
- Write channel:
  - s_axi_wready = 1 when no serial write is busy and bvalid = 0.
  - On wvalid and wready: latch wdata, set busy, raise bvalid on the next cycle.
  - bvalid clears on bready.
  - wvalid while busy waits; the word is not dropped.
- Serializer, all actions on sco_fall:
  - Drive adc_fsin low for one SCO period.
  - Then shift 32 bits out on adc_sdi, MSB first: wdata[31:16] is the register address, wdata[15:0] the register data.
  - After the 32nd bit: fsin = 1, sdi = 0, busy cleared.
- Read channel:
  - arready = ~rvalid.
  - rvalid rises one cycle after the arvalid handshake and clears on rready.
  - rdata: araddr[2] = 0 gives the last written word; araddr[2] = 1 gives {busy, 15'b0, ovf_count[15:0]}.
- Reset values:
  - All AXI and AXIS valid/ready outputs 0, except wready and awready = 1 and arready = 1.
  - tdata = 0, rdata = 0, last written word = 0, ovf_count = 0.
  - adc_fsin = 1, adc_sdi = 0; both FSMs in IDLE.
- Reset mid-frame or mid-write aborts the operation immediately; fsin returns high.

Optional Feature:
- Macro AD7763_OVF_COUNT_EN.
- Defined: overflow counter implemented as specified above.
- Undefined: no counter; rdata[15:0] reads 0 at araddr[2] = 1; samples are still dropped when the output is full.

Decomposition:
- Package ad7763_pkg holds: ADC_DATA_BITS = 24, CFG_WORD_BITS = 32, receive FSM state enum, serializer FSM state enum, register offsets (CFG = 0x0, STATUS = 0x4).
- One sub-module, ad7763_sync_edge: 2-FF synchronizer plus rise/fall detection, instantiated for SCO and synchronize-only for DRDY# and SDO.

Test Plan:
- Reset for 10 ns, then ADC frames carrying 0x000001, 0x000002 with tready = 1 -> tdata 0x000001, then 0x000002, each with one tvalid pulse.
- Write 0x11FF3355 -> fsin low one SCO period, then sdi = 0001 0001 1111 1111 0011 0011 0101 0101; bvalid pulses once; fsin returns high.
- Second write 0xFFFFFFFF issued 50 ns after the first -> wready stays 0 until the first serialization completes, then the word is accepted and serialized.
- tready = 0 for 17 us with frames running -> tdata holds 0x000001 with tvalid = 1; when tready = 1, 0x000001 transfers; STATUS ovf_count equals frames dropped, about 19 (with AD7763_OVF_COUNT_EN).
- Read CFG after the write -> 0x11FF3355; read STATUS during serialization -> bit31 = 1.
- Assert rst mid-frame, release, next full frame 0x0000AB -> tdata 0x0000AB, no corrupted sample emitted.
